tile_compositor: RTL and testbench



---
 rtl/tile_pkg.sv | 29 ++
 rtl/tile_locate.sv | 36 +++
 rtl/tile_compositor.sv | 145 ++++++++++++++
 tb/tb_tile_compositor.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// ============================================================================
// Module      : tile_pkg
// Description : Tile geometry shared by the compositor and its tile locator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tile_pkg;

   localparam int TILE_W    = 240;
   localparam int TILE_H    = 320;
   localparam int NUM_TILES = 4;

   // Origins in screen coordinates: three tiles on the top row, one below T0
   localparam int TILE_X0 [NUM_TILES] = '{50, 390, 730, 50};
   localparam int TILE_Y0 [NUM_TILES] = '{26, 26, 26, 446};

   typedef logic [1:0] tile_idx_t;

   function automatic logic in_rect(input logic [10:0] h, input logic [9:0] v,
                                    input int x0, input int y0,
                                    input int w, input int ht);
      return (int'(h) >= x0) && (int'(h) < x0 + w) &&
             (int'(v) >= y0) && (int'(v) < y0 + ht);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tile_locate.sv
// ============================================================================
// Module      : tile_locate
// Description : Combinational hit test; returns tile index and local x/y.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_locate
   import tile_pkg::*;
(
   input  logic [10:0] i_hcount,
   input  logic [9:0]  i_vcount,
   output logic        o_hit,
   output tile_idx_t   o_idx,
   output logic [7:0]  o_local_x,
   output logic [8:0]  o_local_y
);

   always_comb begin
      o_hit     = 1'b0;
      o_idx     = '0;
      o_local_x = '0;
      o_local_y = '0;
      for (int k = 0; k < NUM_TILES; k++) begin
         if (in_rect(i_hcount, i_vcount, TILE_X0[k], TILE_Y0[k], TILE_W, TILE_H)) begin
            o_hit     = 1'b1;
            o_idx     = tile_idx_t'(k);
            o_local_x = 8'(int'(i_hcount) - TILE_X0[k]);
            o_local_y = 9'(int'(i_vcount) - TILE_Y0[k]);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/tile_compositor.sv
// ============================================================================
// Module      : tile_compositor
// Description : Shared BRAM addressing, tile mux and sync realignment for the
//               four filter tiles. Optional blinking tile border: TILE_BORDER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_compositor
   import tile_pkg::*;
#(
   parameter int BRAM_LAT   = 2,
   parameter int BLINK_BITS = 5
)
(
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic [10:0]                   hcount_in,
   input  logic [9:0]                    vcount_in,
   input  logic                          hsync_in,
   input  logic                          vsync_in,
   input  logic                          blank_in,
   input  tile_idx_t                     sel_in,
   input  logic [NUM_TILES-1:0][6:0]     tile_data_in,
   output logic [16:0]                   addr_out,
   output logic [3:0]                    pixel_out,
   output logic                          hsync_out,
   output logic                          vsync_out,
   output logic                          blank_out
);

   // Sideband stages: locate register, address stage, then BRAM_LAT stages
   localparam int c_depth = BRAM_LAT + 2;
   localparam int c_last  = c_depth - 1;

   logic              w_hit;
   tile_idx_t         w_idx;
   logic [7:0]        w_local_x;
   logic [8:0]        w_local_y;
   logic              w_border;
   logic [16:0]       w_addr;
   logic              w_unused_bits;

   logic [7:0]         r_local_x;
   logic [8:0]         r_local_y;
   logic [c_depth-1:0] r_hit_d;
   logic [c_depth-1:0] r_border_d;
   logic [c_depth-1:0] r_hs_d;
   logic [c_depth-1:0] r_vs_d;
   logic [c_depth-1:0] r_blank_d;
   tile_idx_t          r_idx_d [c_depth];

   tile_locate u_locate (
      .i_hcount  (hcount_in),
      .i_vcount  (vcount_in),
      .o_hit     (w_hit),
      .o_idx     (w_idx),
      .o_local_x (w_local_x),
      .o_local_y (w_local_y)
   );

   // y*240 as y*256 - y*16; the largest result (76799) fits in 17 bits
   assign w_addr = ({r_local_y, 8'b0} - {4'b0, r_local_y, 4'b0}) + {9'b0, r_local_x};

`ifdef TILE_BORDER_EN
   tile_idx_t              r_sel_q;
   logic [BLINK_BITS-1:0]  r_blink_cnt;
   logic                   w_vs_rise;
   logic [NUM_TILES-1:0]   w_ring;

   assign w_vs_rise = vsync_in & ~r_vs_d[0];

   generate
      for (genvar k = 0; k < NUM_TILES; k++) begin : g_ring
         assign w_ring[k] =
            in_rect(hcount_in, vcount_in, TILE_X0[k] - 1, TILE_Y0[k] - 1, TILE_W + 2, TILE_H + 2) &&
            !in_rect(hcount_in, vcount_in, TILE_X0[k], TILE_Y0[k], TILE_W, TILE_H) &&
            !(!r_blink_cnt[BLINK_BITS-1] && (r_sel_q == tile_idx_t'(k)));
      end
   endgenerate

   assign w_border      = |w_ring;
   assign w_unused_bits = ^tile_data_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_sel_q     <= '0;
         r_blink_cnt <= '0;
      end else if (w_vs_rise) begin
         r_sel_q     <= sel_in;
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end
`else
   assign w_border      = 1'b0;
   assign w_unused_bits = ^{tile_data_in, sel_in};
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_local_x  <= '0;
         r_local_y  <= '0;
         r_hit_d    <= '0;
         r_border_d <= '0;
         r_hs_d     <= '0;
         r_vs_d     <= '0;
         r_blank_d  <= '0;
         for (int i = 0; i < c_depth; i++) r_idx_d[i] <= '0;
         addr_out   <= '0;
         pixel_out  <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         blank_out  <= 1'b0;
      end else begin
         r_local_x  <= w_local_x;
         r_local_y  <= w_local_y;
         r_hit_d    <= {r_hit_d[c_last-1:0], w_hit};
         r_border_d <= {r_border_d[c_last-1:0], w_border};
         r_hs_d     <= {r_hs_d[c_last-1:0], hsync_in};
         r_vs_d     <= {r_vs_d[c_last-1:0], vsync_in};
         r_blank_d  <= {r_blank_d[c_last-1:0], blank_in};
         r_idx_d[0] <= w_idx;
         for (int i = 1; i < c_depth; i++) r_idx_d[i] <= r_idx_d[i-1];

         // A miss keeps the last address so the BRAM port does not toggle
         if (r_hit_d[0]) addr_out <= w_addr;

         if (r_blank_d[c_last])
            pixel_out <= 4'h0;
         else if (r_hit_d[c_last])
            pixel_out <= tile_data_in[r_idx_d[c_last]][6:3];
         else if (r_border_d[c_last])
            pixel_out <= 4'hF;
         else
            pixel_out <= 4'h0;

         hsync_out <= r_hs_d[c_last];
         vsync_out <= r_vs_d[c_last];
         blank_out <= r_blank_d[c_last];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tile_compositor.sv
// ============================================================================
// Module      : tb_tile_compositor
// Description : Self-checking bench for tile_compositor with a geometric
//               reference model; border checks built when TILE_BORDER_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tile_compositor;

`ifdef TILE_BORDER_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   logic              clk_in = 1'b0;
   logic              rst_n_in;
   logic [10:0]       hcount;
   logic [9:0]        vcount;
   logic              hsync, vsync, blank;
   logic [1:0]        sel;
   logic [3:0][6:0]   tile_data;
   logic [16:0]       addr_out;
   logic [3:0]        pixel_out;
   logic              hsync_out, vsync_out, blank_out;

   int n_cmp  = 0;
   int n_fail = 0;

   tile_compositor #(.BRAM_LAT(2), .BLINK_BITS(5)) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .hcount_in    (hcount),
      .vcount_in    (vcount),
      .hsync_in     (hsync),
      .vsync_in     (vsync),
      .blank_in     (blank),
      .sel_in       (sel),
      .tile_data_in (tile_data),
      .addr_out     (addr_out),
      .pixel_out    (pixel_out),
      .hsync_out    (hsync_out),
      .vsync_out    (vsync_out),
      .blank_out    (blank_out)
   );

   always #5 clk_in = ~clk_in;

   // ---------------- frame BRAM model: 2-cycle addrb -> doutb ----------------
   logic [16:0] q1 = '0, q2 = '0;
   bit          ovr_en = 1'b0;
   logic [6:0]  ovr [4] = '{7'h7F, 7'h48, 7'h35, 7'h11};

   function automatic logic [6:0] mem_val(int k, int a);
      int t;
      t = a * 13 + (a >> 5) + k * 41;
      return t[6:0];
   endfunction

   always @(posedge clk_in) begin
      q1 <= addr_out;
      q2 <= q1;
   end

   always_comb begin
      for (int k = 0; k < 4; k++) tile_data[k] = ovr_en ? ovr[k] : mem_val(k, int'(q2));
   end

   // ---------------- reference model ----------------
   int ox [4] = '{50, 390, 730, 50};
   int oy [4] = '{26, 26, 26, 446};

   typedef struct {
      bit valid;
      int edge_n;
      int h, v;
      bit hs, vs, bl;
      int sel;
      bit blink;
      int last;
   } samp_t;

   samp_t hist [64];
   samp_t m_s;
   int    cyc = 0;
   int    m_last = 0, m_sel = 0, m_cnt = 0, m_k;
   bit    m_prev_vs = 0;

   function automatic int tile_of(int h, int v);
      for (int k = 0; k < 4; k++)
         if (h >= ox[k] && h < ox[k] + 240 && v >= oy[k] && v < oy[k] + 320) return k;
      return -1;
   endfunction

   function automatic bit ring_on(int h, int v, int s, bit blink);
      for (int k = 0; k < 4; k++)
         if (h >= ox[k] - 1 && h <= ox[k] + 240 && v >= oy[k] - 1 && v <= oy[k] + 320 &&
             tile_of(h, v) != k && !(k == s && !blink)) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk_in) begin
      cyc = cyc + 1;
      if (rst_n_in) begin
         m_k = tile_of(int'(hcount), int'(vcount));
         if (m_k >= 0) m_last = (int'(vcount) - oy[m_k]) * 240 + (int'(hcount) - ox[m_k]);
         m_s.valid  = 1'b1;
         m_s.edge_n = cyc;
         m_s.h      = int'(hcount);
         m_s.v      = int'(vcount);
         m_s.hs     = hsync;
         m_s.vs     = vsync;
         m_s.bl     = blank;
         m_s.sel    = m_sel;
         m_s.blink  = m_cnt[4];
         m_s.last   = m_last;
         hist[cyc % 64] = m_s;
         if (vsync && !m_prev_vs) begin
            m_sel = int'(sel);
            m_cnt = (m_cnt + 1) % 32;
         end
         m_prev_vs = vsync;
      end
   end

   always @(negedge rst_n_in) begin
      for (int i = 0; i < 64; i++) hist[i].valid = 1'b0;
      m_last    = 0;
      m_sel     = 0;
      m_cnt     = 0;
      m_prev_vs = 1'b0;
   end

   function automatic samp_t get(int e);
      samp_t z;
      z = '{default: 0};
      if (e >= 1 && hist[e % 64].valid && hist[e % 64].edge_n == e) return hist[e % 64];
      return z;
   endfunction

   // Outputs observed after edge e: address reflects samples up to e-1,
   // pixel and controls reflect the sample taken at edge e-4.
   function automatic logic [16:0] exp_addr(int e);
      samp_t s;
      s = get(e - 1);
      return s.valid ? 17'(s.last) : 17'd0;
   endfunction

   function automatic logic [2:0] exp_ctl(int e);
      samp_t s;
      s = get(e - 4);
      return {s.hs, s.vs, s.bl};
   endfunction

   function automatic logic [3:0] exp_pix(int e);
      samp_t s;
      int k;
      logic [6:0] d;
      s = get(e - 4);
      if (!s.valid || s.bl) return 4'h0;
      k = tile_of(s.h, s.v);
      if (k >= 0) begin
         d = ovr_en ? ovr[k] : mem_val(k, s.last);
         return d[6:3];
      end
      if (BORDER && ring_on(s.h, s.v, s.sel, s.blink)) return 4'hF;
      return 4'h0;
   endfunction

   task automatic drive(int h, int v, bit hs, bit vs, bit bl);
      hcount = 11'(h);
      vcount = 10'(v);
      hsync  = hs;
      vsync  = vs;
      blank  = bl;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n_in = 1'b0;
      sel = 2'd0;
      drive(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk_in);
      n_cmp += 5;
      if (addr_out  !== 17'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", addr_out); end
      if (pixel_out !== 4'd0)  begin n_fail++; $display("FAIL reset_pixel got=%0h exp=0", pixel_out); end
      if (hsync_out !== 1'b0)  begin n_fail++; $display("FAIL reset_hsync got=%b exp=0", hsync_out); end
      if (vsync_out !== 1'b0)  begin n_fail++; $display("FAIL reset_vsync got=%b exp=0", vsync_out); end
      if (blank_out !== 1'b0)  begin n_fail++; $display("FAIL reset_blank got=%b exp=0", blank_out); end
      rst_n_in = 1'b1;
      blank = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_in);
         n_cmp += 2;
         if (blank_out !== (i >= 4)) begin
            n_fail++; $display("FAIL reset_blank_lat edge=%0d got=%b exp=%b", i, blank_out, i >= 4);
         end
         if (pixel_out !== 4'd0) begin
            n_fail++; $display("FAIL reset_release_pixel edge=%0d got=%0h exp=0", i, pixel_out);
         end
      end
   endtask

   task automatic test_addressing;
      int          th [5] = '{50, 289, 390, 300, 400};
      int          tv [5] = '{26, 345, 27, 100, 200};
      bit          tb_bl [5] = '{0, 0, 0, 0, 1};
      logic [16:0] ea [5] = '{17'd0, 17'd76799, 17'd240, 17'd240, 17'd41770};
      logic [3:0]  ep [5] = '{4'hF, 4'hF, 4'h9, 4'h0, 4'h0};
      logic [16:0] prev_a = 17'd0;
      logic [3:0]  prev_p = 4'h0;
      ovr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(th[i], tv[i], 0, 0, tb_bl[i]);
         for (int n = 1; n <= 5; n++) begin
            @(negedge clk_in);
            if (n == 1) begin
               n_cmp++;
               if (addr_out !== prev_a) begin n_fail++; $display("FAIL addr_early pt=%0d got=%0d exp=%0d", i, addr_out, prev_a); end
            end
            if (n == 2) begin
               n_cmp++;
               if (addr_out !== ea[i]) begin n_fail++; $display("FAIL addr pt=%0d got=%0d exp=%0d", i, addr_out, ea[i]); end
            end
            if (n == 4) begin
               n_cmp++;
               if (pixel_out !== prev_p) begin n_fail++; $display("FAIL pixel_early pt=%0d got=%0h exp=%0h", i, pixel_out, prev_p); end
            end
            if (n == 5) begin
               n_cmp++;
               if (pixel_out !== ep[i]) begin n_fail++; $display("FAIL pixel pt=%0d got=%0h exp=%0h", i, pixel_out, ep[i]); end
            end
         end
         prev_a = ea[i];
         prev_p = ep[i];
      end
   endtask

   task automatic test_random;
      int k, h, v, e;
      ovr_en = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_in);
         e = cyc;
         n_cmp += 3;
         if (addr_out !== exp_addr(e)) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", e, addr_out, exp_addr(e)); end
         if (pixel_out !== exp_pix(e)) begin n_fail++; $display("FAIL rnd_pixel cyc=%0d got=%0h exp=%0h", e, pixel_out, exp_pix(e)); end
         if ({hsync_out, vsync_out, blank_out} !== exp_ctl(e)) begin
            n_fail++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", e, {hsync_out, vsync_out, blank_out}, exp_ctl(e));
         end
         if ($urandom_range(0, 3) == 0) begin
            h = $urandom_range(0, 1343);
            v = $urandom_range(0, 805);
         end else begin
            k = $urandom_range(0, 3);
            h = ox[k] - 2 + $urandom_range(0, 244);
            v = oy[k] - 2 + $urandom_range(0, 324);
         end
         sel = 2'($urandom_range(0, 3));
         drive(h, v, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
      end
   endtask

   task automatic test_frame;
      int lines [7] = '{25, 26, 345, 346, 445, 446, 765};
      int e;
      for (int l = 0; l < 7; l++) begin
         for (int h = 0; h < 1344; h++) begin
            @(negedge clk_in);
            e = cyc;
            n_cmp += 3;
            if (addr_out !== exp_addr(e)) begin n_fail++; $display("FAIL frm_addr cyc=%0d got=%0d exp=%0d", e, addr_out, exp_addr(e)); end
            if (pixel_out !== exp_pix(e)) begin n_fail++; $display("FAIL frm_pixel cyc=%0d got=%0h exp=%0h", e, pixel_out, exp_pix(e)); end
            if ({hsync_out, vsync_out, blank_out} !== exp_ctl(e)) begin
               n_fail++; $display("FAIL frm_ctl cyc=%0d got=%b exp=%b", e, {hsync_out, vsync_out, blank_out}, exp_ctl(e));
            end
            drive(h, lines[l], (h >= 1048 && h < 1184), (lines[l] == 25), (h >= 1024 || lines[l] >= 768));
         end
      end
   endtask

`ifdef TILE_BORDER_EN
   task automatic test_border;
      int e, t2_on = 0, t2_off = 0;
      samp_t s;
      ovr_en = 1'b0;
      @(negedge clk_in) rst_n_in = 1'b0;
      sel = 2'd0;
      drive(49, 100, 0, 0, 0);
      @(negedge clk_in) rst_n_in = 1'b1;
      for (int f = 0; f < 40; f++) begin
         for (int c = 0; c < 24; c++) begin
            @(negedge clk_in);
            e = cyc;
            n_cmp += 2;
            if (pixel_out !== exp_pix(e)) begin n_fail++; $display("FAIL brd_pixel cyc=%0d got=%0h exp=%0h", e, pixel_out, exp_pix(e)); end
            if (addr_out !== exp_addr(e)) begin n_fail++; $display("FAIL brd_addr cyc=%0d got=%0d exp=%0d", e, addr_out, exp_addr(e)); end
            s = get(e - 4);
            if (s.valid && s.h == 729 && s.sel == 2) begin
               if (pixel_out === 4'hF) t2_on++;
               else t2_off++;
            end
            if (f == 3 && c == 12) sel = 2'd2;
            drive((c % 2) ? 729 : 49, 100, 0, c < 2, 0);
         end
      end
      n_cmp += 2;
      if (t2_on == 0)  begin n_fail++; $display("FAIL brd_t2_blink_on got=%0d exp=>0", t2_on); end
      if (t2_off == 0) begin n_fail++; $display("FAIL brd_t2_blink_off got=%0d exp=>0", t2_off); end
   endtask
`endif

   task automatic test_async_reset;
      ovr_en = 1'b1;
      drive(600, 100, 1, 0, 0);
      repeat (8) @(negedge clk_in);
      @(posedge clk_in);
      #2 rst_n_in = 1'b0;
      #1;
      n_cmp += 5;
      if (addr_out  !== 17'd0) begin n_fail++; $display("FAIL arst_addr got=%0d exp=0", addr_out); end
      if (pixel_out !== 4'd0)  begin n_fail++; $display("FAIL arst_pixel got=%0h exp=0", pixel_out); end
      if (hsync_out !== 1'b0)  begin n_fail++; $display("FAIL arst_hsync got=%b exp=0", hsync_out); end
      if (vsync_out !== 1'b0)  begin n_fail++; $display("FAIL arst_vsync got=%b exp=0", vsync_out); end
      if (blank_out !== 1'b0)  begin n_fail++; $display("FAIL arst_blank got=%b exp=0", blank_out); end
      @(negedge clk_in) rst_n_in = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_in);
         n_cmp += 3;
         if (pixel_out !== ((i >= 4) ? 4'h9 : 4'h0)) begin
            n_fail++; $display("FAIL arst_pixel_lat edge=%0d got=%0h exp=%0h", i, pixel_out, (i >= 4) ? 4'h9 : 4'h0);
         end
         if (hsync_out !== (i >= 4)) begin
            n_fail++; $display("FAIL arst_hsync_lat edge=%0d got=%b exp=%b", i, hsync_out, i >= 4);
         end
         if (addr_out !== ((i >= 1) ? 17'd17970 : 17'd0)) begin
            n_fail++; $display("FAIL arst_addr_lat edge=%0d got=%0d exp=%0d", i, addr_out, (i >= 1) ? 17970 : 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_addressing();
      test_random();
      test_frame();
`ifdef TILE_BORDER_EN
      test_border();
`endif
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
